// File: rtl/ezusb_sync_if.sv
// rtl/ezusb_sync_if.sv - EZ-USB FX2 synchronous slave-FIFO bridge (EP2 OUT -> RX FIFO, TX FIFO -> EP6 IN)
// Define EZUSB_IN_PRIORITY_EN to always favour EP6 IN; otherwise the two directions alternate.
module ezusb_sync_if #(
    parameter int MAX_BURST = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_fifo_fullm1,
    output logic       rx_fifo_wr,
    output logic [7:0] wdata,
    input  logic       tx_fifo_emptyp1,
    output logic       tx_fifo_rd,
    input  logic [7:0] rdata,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       data_en,
    input  logic       ep2out_emptyp1_n,
    input  logic       ep6in_fullm2_n,
    input  logic       ep6in_full_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       oe_n,
    output logic [1:0] fifoaddr
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_BURST,
        WR_SETUP,
        WR_BURST,
        TURN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          valid;
    logic          rd_ok;
    logic          wr_ok;
    logic          below_max;
    logic          wr_pop;
    logic          rd_take;
    logic          grant_wr;

    assign rd_ok     = ep2out_emptyp1_n & ~rx_fifo_fullm1;
    assign wr_ok     = ~tx_fifo_emptyp1 & ep6in_fullm2_n & ep6in_full_n;
    assign below_max = (cnt < CNT_MAX);
    assign wr_pop    = wr_ok & below_max;
    assign rd_take   = ~rd_n & ~oe_n;
    assign data_o    = valid ? rdata : 8'h00;

`ifdef EZUSB_IN_PRIORITY_EN
    assign grant_wr = 1'b1;
`else
    logic last_wr;

    assign grant_wr = ~last_wr;

    // Reset as though a write was served last so the first grant goes to read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_wr <= 1'b1;
        end else if (state_nxt == RD_SETUP) begin
            last_wr <= 1'b0;
        end else if (state_nxt == WR_SETUP) begin
            last_wr <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt  = state;
        rd_n       = 1'b1;
        wr_n       = 1'b1;
        oe_n       = 1'b1;
        data_en    = 1'b0;
        fifoaddr   = 2'b00;
        tx_fifo_rd = 1'b0;
        case (state)
            IDLE: begin
                if (rd_ok && wr_ok) begin
                    state_nxt = grant_wr ? WR_SETUP : RD_SETUP;
                end else if (rd_ok) begin
                    state_nxt = RD_SETUP;
                end else if (wr_ok) begin
                    state_nxt = WR_SETUP;
                end
            end
            RD_SETUP: begin
                oe_n      = 1'b0;
                state_nxt = RD_BURST;
            end
            RD_BURST: begin
                oe_n = 1'b0;
                rd_n = ~(rd_ok & below_max);
                if (!(rd_ok && below_max)) begin
                    state_nxt = TURN;
                end
            end
            WR_SETUP: begin
                fifoaddr  = 2'b10;
                data_en   = 1'b1;
                state_nxt = WR_BURST;
            end
            WR_BURST: begin
                fifoaddr   = 2'b10;
                data_en    = 1'b1;
                tx_fifo_rd = wr_pop;
                wr_n       = ~(valid & ep6in_full_n);
                // Leave only once pops have stopped and no word is stuck behind a full EP6.
                if (!wr_pop && (!valid || ep6in_full_n)) begin
                    state_nxt = TURN;
                end
            end
            TURN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            valid      <= 1'b0;
            rx_fifo_wr <= 1'b0;
            wdata      <= 8'h00;
        end else begin
            state      <= state_nxt;
            valid      <= tx_fifo_rd | (valid & ~ep6in_full_n);
            rx_fifo_wr <= rd_take;
            if (rd_take) begin
                wdata <= data_i;
            end
            if (state_nxt == RD_SETUP || state_nxt == WR_SETUP) begin
                cnt <= '0;
            end else if ((rd_take || tx_fifo_rd) && below_max) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ezusb_sync_if.sv
// tb/tb_ezusb_sync_if.sv - self-checking bench for ezusb_sync_if with FX2 and FIFO models
module tb_ezusb_sync_if;

    localparam int MB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_fifo_fullm1;
    logic       rx_fifo_wr;
    logic [7:0] wdata;
    logic       tx_fifo_emptyp1;
    logic       tx_fifo_rd;
    logic [7:0] rdata = 8'h00;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       data_en;
    logic       ep2out_emptyp1_n;
    logic       ep6in_fullm2_n;
    logic       ep6in_full_n;
    logic       rd_n;
    logic       wr_n;
    logic       oe_n;
    logic [1:0] fifoaddr;

    always #5 clk = ~clk;

    int         ep2_cnt = 0;
    int         rx_cnt = 0;
    int         rx_cap = 1000;
    int         tx_cnt = 0;
    int         ep6_cnt = 0;
    int         ep6_cap = 1000;
    logic [7:0] ep2_next = 8'h00;
    logic [7:0] tx_next = 8'h00;
    logic       full_force = 1'b0;

    int         total = 0;
    int         passed = 0;
    int         rx_got = 0;
    int         tx_got = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    logic       prev_rd = 1'b0;
    logic       prev_oe = 1'b1;
    logic       prev_de = 1'b0;
    logic       cont = 1'b0;
    int         rlen = 0;
    int         wlen = 0;
    int         last_dir = 0;
    int         nbursts = 0;

    assign data_i           = ep2_next;
    assign ep2out_emptyp1_n = (ep2_cnt >= 2);
    assign rx_fifo_fullm1   = ((rx_cap - rx_cnt) <= 1);
    assign tx_fifo_emptyp1  = (tx_cnt <= 1);
    assign ep6in_full_n     = (ep6_cnt < ep6_cap) && !full_force;
    assign ep6in_fullm2_n   = ((ep6_cap - ep6_cnt) > 2) && !full_force;

    ezusb_sync_if #(.MAX_BURST(MB)) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_fifo_fullm1   (rx_fifo_fullm1),
        .rx_fifo_wr       (rx_fifo_wr),
        .wdata            (wdata),
        .tx_fifo_emptyp1  (tx_fifo_emptyp1),
        .tx_fifo_rd       (tx_fifo_rd),
        .rdata            (rdata),
        .data_i           (data_i),
        .data_o           (data_o),
        .data_en          (data_en),
        .ep2out_emptyp1_n (ep2out_emptyp1_n),
        .ep6in_fullm2_n   (ep6in_fullm2_n),
        .ep6in_full_n     (ep6in_full_n),
        .rd_n             (rd_n),
        .wr_n             (wr_n),
        .oe_n             (oe_n),
        .fifoaddr         (fifoaddr)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_n"}, int'(rd_n), 1);
        check({tag, "_wr_n"}, int'(wr_n), 1);
        check({tag, "_oe_n"}, int'(oe_n), 1);
        check({tag, "_data_en"}, int'(data_en), 0);
        check({tag, "_fifoaddr"}, int'(fifoaddr), 0);
        check({tag, "_rx_fifo_wr"}, int'(rx_fifo_wr), 0);
        check({tag, "_tx_fifo_rd"}, int'(tx_fifo_rd), 0);
        check({tag, "_wdata"}, int'(wdata), 0);
        check({tag, "_data_o"}, int'(data_o), 0);
    endtask

    task automatic end_burst(input int dir, input int len);
        check("burst_max", int'(len <= MB), 1);
        if (cont) begin
            check("burst_len", len, MB);
            check("turn_gap", int'({oe_n, data_en, rd_n, wr_n}), 4'b1011);
`ifdef EZUSB_IN_PRIORITY_EN
            check("burst_dir", dir, 2);
`else
            check("burst_dir", dir, (last_dir == 1) ? 2 : 1);
`endif
            nbursts++;
        end
        last_dir = dir;
    endtask

    // FX2 endpoints, RX/TX FIFOs and scoreboard: sample at negedge, act just after posedge.
    always begin : model
        logic s_rd;
        logic s_pop;
        logic s_wr;
        logic s_rxw;
        @(negedge clk);
        s_rd  = 1'b0;
        s_pop = 1'b0;
        s_wr  = 1'b0;
        s_rxw = 1'b0;
        if (rst) begin
            prev_oe = 1'b1;
            prev_de = 1'b0;
            rlen    = 0;
            wlen    = 0;
        end else begin
            s_rd  = !rd_n && !oe_n;
            s_pop = tx_fifo_rd;
            s_wr  = !wr_n;
            s_rxw = rx_fifo_wr;
            check("oe_de_excl", int'(!oe_n && data_en), 0);
            check("rx_wr_latency", int'(rx_fifo_wr), int'(prev_rd));
            if (!rd_n)
                check("rd_qualified", int'(ep2out_emptyp1_n && !rx_fifo_fullm1 && fifoaddr == 2'b00), 1);
            if (rx_fifo_wr) begin
                if (rx_exp.size() == 0) check("rx_unexpected", 1, 0);
                else check("rx_data", int'(wdata), int'(rx_exp.pop_front()));
                rx_got++;
            end
            if (s_wr) begin
                check("wr_while_full", int'(ep6in_full_n), 1);
                check("wr_dir", int'({data_en, fifoaddr}), 3'b110);
                if (tx_exp.size() == 0) check("tx_unexpected", 1, 0);
                else check("tx_data", int'(data_o), int'(tx_exp.pop_front()));
            end
            if (s_rd) rlen++;
            if (s_wr) wlen++;
            if (!prev_oe && oe_n) begin
                end_burst(1, rlen);
                rlen = 0;
            end
            if (prev_de && !data_en) begin
                end_burst(2, wlen);
                wlen = 0;
            end
            prev_oe = oe_n;
            prev_de = data_en;
        end
        prev_rd = s_rd;
        @(posedge clk);
        #1;
        if (!rst) begin
            if (s_rd) begin
                rx_exp.push_back(ep2_next);
                ep2_next++;
                ep2_cnt--;
            end
            if (s_rxw) rx_cnt++;
            if (s_pop) begin
                rdata = tx_next;
                tx_exp.push_back(tx_next);
                tx_next++;
                tx_cnt--;
            end
            if (s_wr) begin
                ep6_cnt++;
                tx_got++;
            end
        end
    end

    typedef struct {
        int ep2;
        int rxcap;
        int tx;
        int ep6cap;
        int exp_rx;
        int exp_tx;
    } vec_t;

    vec_t vecs[8];

    task automatic start_scenario(input vec_t v);
        @(posedge clk);
        #3;
        rst        = 1'b1;
        ep2_cnt    = v.ep2;
        ep2_next   = 8'h00;
        rx_cnt     = 0;
        rx_cap     = v.rxcap;
        tx_cnt     = v.tx;
        tx_next    = 8'h00;
        ep6_cnt    = 0;
        ep6_cap    = v.ep6cap;
        rdata      = 8'h00;
        full_force = 1'b0;
        rx_exp.delete();
        tx_exp.delete();
        rx_got     = 0;
        tx_got     = 0;
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int tx_rel;
        vecs[0] = '{8, 1000, 0, 1000, 7, 0};
        vecs[1] = '{8, 4, 0, 1000, 4, 0};
        vecs[2] = '{0, 1000, 15, 8, 0, 7};
        vecs[3] = '{0, 1000, 15, 1000, 0, 14};
        vecs[4] = '{3, 1000, 0, 1000, 2, 0};
        vecs[5] = '{1, 1000, 1, 1000, 0, 0};
        vecs[6] = '{5, 1000, 5, 1000, 4, 4};
        vecs[7] = '{20, 1000, 0, 1000, 19, 0};

        #2;
        check_idle_outputs("reset");

        for (int i = 0; i < 8; i++) begin
            start_scenario(vecs[i]);
            repeat (80) @(posedge clk);
            #4;
            check($sformatf("v%0d_rx_count", i), rx_got, vecs[i].exp_rx);
            check($sformatf("v%0d_tx_count", i), tx_got, vecs[i].exp_tx);
            check($sformatf("v%0d_rx_drained", i), rx_exp.size(), 0);
            check($sformatf("v%0d_tx_drained", i), tx_exp.size(), 0);
        end

        start_scenario('{10000, 100000, 10000, 100000, 0, 0});
        cont     = 1'b1;
        last_dir = 0;
        nbursts  = 0;
        repeat (120) @(posedge clk);
        #4;
        cont = 1'b0;
        check("cont_bursts", int'(nbursts >= 6), 1);

        start_scenario('{0, 1000, 10, 1000, 0, 0});
        n = 0;
        while (wr_n !== 1'b0 && n < 40) begin
            @(posedge clk);
            #4;
            n++;
        end
        check("hold_write_seen", int'(wr_n), 0);
        full_force = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #4;
            check("hold_wr_n", int'(wr_n), 1);
            check("hold_pop", int'(tx_fifo_rd), 0);
            check("hold_data_en", int'(data_en), 1);
            check("hold_pending", tx_exp.size(), 1);
            if (tx_exp.size() > 0) check("hold_data", int'(data_o), int'(tx_exp[0]));
        end
        full_force = 1'b0;
        repeat (40) @(posedge clk);
        #4;
        check("hold_tx_count", tx_got, 9);
        check("hold_tx_drained", tx_exp.size(), 0);

        start_scenario('{0, 1000, 40, 100000, 0, 0});
        n = 0;
        while (wr_n !== 1'b0 && n < 40) begin
            @(posedge clk);
            #4;
            n++;
        end
        check("async_write_seen", int'(wr_n), 0);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("async");
        @(posedge clk);
        #3;
        check_idle_outputs("async_hold");
        tx_exp.delete();
        rx_exp.delete();
        tx_got = 0;
        tx_rel = tx_cnt;
        @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (80) @(posedge clk);
        #4;
        check("resume_writes", tx_got, tx_rel - 1);
        check("resume_tx_left", tx_cnt, 1);
        check("resume_drained", tx_exp.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
